// File: rtl/raw_check_sequencer.sv
// raw_check_sequencer: round-robin front end that time-shares one RAW
// dependency checker among several issue threads. It latches the winning
// request and walks its used operands through the checker one per cycle,
// then presents the per-operand hit/index results on a valid/ready port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | arbitrating; req_ready_o asserted for the round-robin winner
// LOOKUP | driving operand k_q to the checker, capturing its result
// RESP   | results valid, waiting for rsp_ready_i
module raw_check_sequencer #(
    parameter int unsigned NUM_THREADS   = 2,
    parameter int unsigned NR_OPERANDS   = 3,
    parameter int unsigned REG_ADDR_SIZE = 5,
    parameter int unsigned TRANS_ID_BITS = 3,
    localparam int unsigned TidW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic                                               flush_i,
    input  logic [NUM_THREADS-1:0]                             req_valid_i,
    output logic [NUM_THREADS-1:0]                             req_ready_o,
    input  logic [NUM_THREADS*NR_OPERANDS*REG_ADDR_SIZE-1:0]   req_rs_i,
    input  logic [NUM_THREADS*NR_OPERANDS-1:0]                 req_rs_fpr_i,
    input  logic [NUM_THREADS*NR_OPERANDS-1:0]                 req_rs_used_i,
    output logic [REG_ADDR_SIZE-1:0]                           chk_rs_o,
    output logic                                               chk_rs_fpr_o,
    output logic [TidW-1:0]                                    chk_thread_id_o,
    input  logic                                               chk_valid_i,
    input  logic [TRANS_ID_BITS-1:0]                           chk_idx_i,
    output logic                                               rsp_valid_o,
    input  logic                                               rsp_ready_i,
    output logic [TidW-1:0]                                    rsp_thread_id_o,
    output logic [NR_OPERANDS-1:0]                             rsp_hit_o,
    output logic [NR_OPERANDS*TRANS_ID_BITS-1:0]               rsp_idx_o
);

    localparam int unsigned KW = (NR_OPERANDS > 1) ? $clog2(NR_OPERANDS) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

    state_e                             state_q, state_d;
    logic [TidW-1:0]                    rr_q;
    logic [TidW-1:0]                    tid_q;
    logic [NR_OPERANDS*REG_ADDR_SIZE-1:0] rs_q;
    logic [NR_OPERANDS-1:0]             fpr_q;
    logic [NR_OPERANDS-1:0]             used_q;
    logic [KW-1:0]                      k_q;
    logic [NR_OPERANDS-1:0]             hit_q;
    logic [NR_OPERANDS*TRANS_ID_BITS-1:0] idx_q;

    logic                               found;
    logic [TidW-1:0]                    win;
    logic                               accept;
    logic [NR_OPERANDS*REG_ADDR_SIZE-1:0] sel_rs;
    logic [NR_OPERANDS-1:0]             sel_fpr;
    logic [NR_OPERANDS-1:0]             sel_used;
    logic [KW-1:0]                      first_k;
    logic [KW-1:0]                      next_k;
    logic                               has_next;

    // Round-robin pick: first valid thread at or after the rr pointer.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
            cand = int'(rr_q) + i;
            if (cand >= int'(NUM_THREADS)) cand = cand - int'(NUM_THREADS);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = TidW'(cand);
            end
        end
    end

    assign accept   = (state_q == IDLE) && found && !flush_i;
    assign sel_rs   = req_rs_i[int'(win)*NR_OPERANDS*REG_ADDR_SIZE +: NR_OPERANDS*REG_ADDR_SIZE];
    assign sel_fpr  = req_rs_fpr_i[int'(win)*NR_OPERANDS +: NR_OPERANDS];
    assign sel_used = req_rs_used_i[int'(win)*NR_OPERANDS +: NR_OPERANDS];

    // Operand walk: first used operand of the winner, next used operand after k_q.
    always_comb begin
        first_k  = '0;
        next_k   = k_q;
        has_next = 1'b0;
        for (int i = int'(NR_OPERANDS) - 1; i >= 0; i--) begin
            if (sel_used[i]) first_k = KW'(i);
            if (used_q[i] && (KW'(i) > k_q)) begin
                has_next = 1'b1;
                next_k   = KW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (found) state_d = (|sel_used) ? LOOKUP : RESP;
                LOOKUP:  if (!has_next) state_d = RESP;
                RESP:    if (rsp_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state; the checker sees x0/GPR when not looking up.
    always_comb begin
        req_ready_o     = '0;
        chk_rs_o        = '0;
        chk_rs_fpr_o    = 1'b0;
        chk_thread_id_o = '0;
        if (accept) req_ready_o[win] = 1'b1;
        if (state_q == LOOKUP) begin
            chk_rs_o        = rs_q[int'(k_q)*REG_ADDR_SIZE +: REG_ADDR_SIZE];
            chk_rs_fpr_o    = fpr_q[k_q];
            chk_thread_id_o = tid_q;
        end
    end

    // Request latch, rr pointer and per-operand result capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            tid_q  <= '0;
            rs_q   <= '0;
            fpr_q  <= '0;
            used_q <= '0;
            k_q    <= '0;
            hit_q  <= '0;
            idx_q  <= '0;
        end else if (!flush_i) begin
            if (accept) begin
                tid_q  <= win;
                rs_q   <= sel_rs;
                fpr_q  <= sel_fpr;
                used_q <= sel_used;
                k_q    <= first_k;
                hit_q  <= '0;
                idx_q  <= '0;
                rr_q   <= (win == TidW'(NUM_THREADS - 1)) ? '0 : win + TidW'(1);
            end
            if (state_q == LOOKUP) begin
                hit_q[k_q] <= chk_valid_i;
                idx_q[int'(k_q)*TRANS_ID_BITS +: TRANS_ID_BITS] <= chk_valid_i ? chk_idx_i : '0;
                k_q <= next_k;
            end
        end
    end

    assign rsp_valid_o     = (state_q == RESP);
    assign rsp_thread_id_o = tid_q;
    assign rsp_hit_o       = hit_q;
    assign rsp_idx_o       = idx_q;

endmodule
